// File: rtl/mult_share_ctrl.sv
// Round-robin controller sharing one external serial signed multiplier
// among nr requesters. Operands are captured on a one-cycle ack pulse, the
// multiplier is launched with a one-cycle start, and the product (or a
// timeout error) is returned to the granted requester with a done pulse.
module mult_share_ctrl #(
    parameter int nb = 8,
    parameter int nr = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [nr-1:0]          req,
    input  logic [nr*nb-1:0]       req_a,
    input  logic [nr*nb-1:0]       req_b,
    output logic [nr-1:0]          ack,
    output logic [nr-1:0]          done,
    output logic signed [2*nb-1:0] result,
    output logic                   err,
    output logic                   busy,
    output logic                   mul_start,
    output logic signed [nb-1:0]   mul_A,
    output logic signed [nb-1:0]   mul_B,
    input  logic                   mul_ready,
    input  logic signed [2*nb-1:0] mul_product
);

    localparam int GW  = $clog2(nr);
    localparam int WCW = $clog2(nb + 3);
    localparam logic [WCW-1:0] WCNT_MAX = WCW'(nb + 2);
    localparam logic [nr-1:0]  ONE_HOT0 = nr'(1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

    state_t          state;
    logic [GW-1:0]   last;
    logic [GW-1:0]   gnt;
    logic [WCW-1:0]  wcnt;
    logic [GW-1:0]   win;
    logic [GW-1:0]   cand;
    logic [nb-1:0]   win_a;
    logic [nb-1:0]   win_b;

    // Round-robin winner: first requester found searching upward from last+1.
    // Walking the distance downward lets the nearest candidate overwrite.
    always_comb begin
        win  = last;
        cand = last;
        for (int k = nr; k >= 1; k--) begin
            cand = GW'((int'(last) + k) % nr);
            if (req[cand]) win = cand;
        end
    end

    assign win_a = req_a[win*nb +: nb];
    assign win_b = req_b[win*nb +: nb];

    // Grant / launch / wait sequencer with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= GW'(nr - 1);
            gnt       <= '0;
            wcnt      <= '0;
            ack       <= '0;
            done      <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            mul_start <= 1'b0;
            mul_A     <= '0;
            mul_B     <= '0;
            result    <= '0;
        end else begin
            ack  <= '0;
            done <= '0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        ack       <= ONE_HOT0 << win;
                        mul_A     <= win_a;
                        mul_B     <= win_b;
                        mul_start <= 1'b1;
                        gnt       <= win;
                        last      <= win;
                        busy      <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    mul_start <= 1'b0;
                    wcnt      <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    // A ready seen in the first WAIT cycle may be left over
                    // from the previous product, so it is not trusted.
                    if (mul_ready && (wcnt != '0)) begin
                        result    <= mul_product;
                        done[gnt] <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (wcnt == WCNT_MAX) begin
                        result    <= '0;
                        err       <= 1'b1;
                        done[gnt] <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        wcnt <= wcnt + WCW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Scoreboard bench for mult_share_ctrl with a serial-multiplier stub.
module tb_mult_share_ctrl;
    localparam int NB = 8;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NR-1:0]          req   = '0;
    logic [NR*NB-1:0]       req_a = '0;
    logic [NR*NB-1:0]       req_b = '0;
    logic [NR-1:0]          ack;
    logic [NR-1:0]          done;
    logic signed [2*NB-1:0] result;
    logic                   err;
    logic                   busy;
    logic                   mul_start;
    logic signed [NB-1:0]   mul_A;
    logic signed [NB-1:0]   mul_B;
    logic                   mul_ready = 1'b0;
    logic [2*NB-1:0]        mul_product = '0;

    logic stub_timeout = 1'b0;
    logic stale_mode   = 1'b0;

    int cyc = 0;
    int n_checks = 0;
    int n_err = 0;

    typedef struct { int cyc; int idx; logic [NB-1:0] a; logic [NB-1:0] b; } ack_t;
    typedef struct { int cyc; int idx; logic [2*NB-1:0] res; logic err; } done_t;
    ack_t  ack_q[$];
    done_t done_q[$];

    mult_share_ctrl #(.nb(NB), .nr(NR)) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
        .ack(ack), .done(done), .result(result), .err(err), .busy(busy),
        .mul_start(mul_start), .mul_A(mul_A), .mul_B(mul_B),
        .mul_ready(mul_ready), .mul_product(mul_product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // Serial multiplier stub: samples start, raises ready nb cycles later and
    // holds it until the next start. In stale mode ready lingers one extra
    // cycle after start; in timeout mode ready never rises.
    int scnt = 0;
    always @(posedge clk) begin
        if (mul_start) begin
            scnt <= stub_timeout ? 0 : 1;
            if (!stale_mode || stub_timeout) mul_ready <= 1'b0;
        end else if (scnt != 0) begin
            if (scnt == 1) mul_ready <= 1'b0;
            if (scnt == NB) begin
                mul_ready   <= 1'b1;
                mul_product <= $signed(mul_A) * $signed(mul_B);
                scnt        <= 0;
            end else begin
                scnt <= scnt + 1;
            end
        end
    end

    // Transaction-level reference: a grant is a fixed-length occupation of
    // the multiplier; the next grant may happen one edge after done.
    int idle_at = 0;
    int m_last = NR - 1;
    int bz_from = 0;
    int bz_to = 0;
    int res_clear_cyc = -1;
    always @(posedge clk) begin
        int w;
        int dc;
        logic [NB-1:0] a;
        logic [NB-1:0] b;
        logic signed [2*NB-1:0] p;
        cyc++;
        if (rst) begin
            while (ack_q.size() > 0 && ack_q[$].cyc >= cyc) void'(ack_q.pop_back());
            while (done_q.size() > 0 && done_q[$].cyc >= cyc) void'(done_q.pop_back());
            idle_at = 0;
            m_last = NR - 1;
            bz_from = 0;
            bz_to = 0;
            res_clear_cyc = cyc;
        end else if (cyc >= idle_at && req != '0) begin
            w = -1;
            for (int k = 1; k <= NR; k++) begin
                if (w < 0 && req[(m_last + k) % NR]) w = (m_last + k) % NR;
            end
            a = req_a[w*NB +: NB];
            b = req_b[w*NB +: NB];
            p = $signed(a) * $signed(b);
            dc = cyc + (stub_timeout ? NB + 4 : NB + 2);
            ack_q.push_back('{cyc, w, a, b});
            if (stub_timeout) done_q.push_back('{dc, w, '0, 1'b1});
            else              done_q.push_back('{dc, w, p, 1'b0});
            m_last = w;
            idle_at = dc + 1;
            bz_from = cyc;
            bz_to = dc;
        end
    end

    // Monitor: compares every output each cycle against the scoreboard.
    logic [NR-1:0]   exp_ack;
    logic [NR-1:0]   exp_done;
    logic [2*NB-1:0] exp_result = '0;
    logic [NB-1:0]   exp_ma = '0;
    logic [NB-1:0]   exp_mb = '0;
    ack_t            ae;
    done_t           de;
    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (cyc == res_clear_cyc) begin
                exp_result = '0;
                exp_ma = '0;
                exp_mb = '0;
            end
            exp_ack = '0;
            if (ack_q.size() > 0 && ack_q[0].cyc == cyc) begin
                ae = ack_q.pop_front();
                exp_ack = NR'(1) << ae.idx;
                exp_ma = ae.a;
                exp_mb = ae.b;
                chk("mul_start", 32'(mul_start), 32'd1);
            end else begin
                chk("mul_start", 32'(mul_start), 32'd0);
            end
            chk("ack", 32'(ack), 32'(exp_ack));
            chk("mul_A", 32'($unsigned(mul_A)), 32'(exp_ma));
            chk("mul_B", 32'($unsigned(mul_B)), 32'(exp_mb));
            exp_done = '0;
            if (done_q.size() > 0 && done_q[0].cyc == cyc) begin
                de = done_q.pop_front();
                exp_done = NR'(1) << de.idx;
                exp_result = de.res;
                chk("err", 32'(err), 32'(de.err));
            end else begin
                chk("err", 32'(err), 32'd0);
            end
            chk("done", 32'(done), 32'(exp_done));
            chk("result", 32'($unsigned(result)), 32'(exp_result));
            chk("busy", 32'(busy), (cyc >= bz_from && cyc < bz_to) ? 32'd1 : 32'd0);
        end
    end

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            if (req[i] && ack[i]) req[i] = 1'b0;
            if (!req[i]) begin
                req_a[i*NB +: NB] = NB'($urandom);
                req_b[i*NB +: NB] = NB'($urandom);
            end
        end
    endtask

    task automatic issue(input int i, input logic [NB-1:0] a, input logic [NB-1:0] b);
        req[i] = 1'b1;
        req_a[i*NB +: NB] = a;
        req_b[i*NB +: NB] = b;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((ack_q.size() > 0 || done_q.size() > 0 || req != '0) && k < 400) begin
            step();
            k++;
        end
        if (k >= 400) begin
            n_checks++;
            n_err++;
            $display("FAIL drain_timeout cycle %0d: %0d cycles without going idle", cyc, k);
        end
        repeat (3) step();
    endtask

    task automatic hold_all(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            step();
            for (int i = 0; i < NR; i++)
                if (!req[i]) issue(i, NB'($urandom), NB'($urandom));
        end
    endtask

    initial begin
        int k;
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();

        // single and signed operations
        issue(0, 8'd7, 8'd6);
        repeat (14) step();
        issue(0, 8'hFD, 8'd5);
        repeat (14) step();
        issue(0, 8'd4, 8'hFE);
        repeat (14) step();

        // everyone requesting
        hold_all(60);
        drain();

        // fairness after a grant to requester 1
        issue(1, 8'd11, 8'd3);
        k = 0;
        while (!ack[1] && k < 20) begin
            step();
            k++;
        end
        issue(0, 8'd2, 8'd9);
        issue(2, 8'hF0, 8'd16);
        drain();

        // reset during WAIT, then all request
        issue(3, 8'd5, 8'd5);
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        hold_all(50);
        drain();

        // operand extremes
        issue(2, 8'h80, 8'h80);
        issue(3, 8'h80, 8'h7F);
        issue(1, 8'h7F, 8'h7F);
        drain();

        // multiplier timeout
        stub_timeout = 1'b1;
        issue(0, 8'd9, 8'd9);
        repeat (16) step();
        issue(1, 8'd1, 8'd2);
        issue(3, 8'd3, 8'd4);
        drain();
        stub_timeout = 1'b0;

        // random traffic with a lingering ready
        stale_mode = 1'b1;
        for (int c = 0; c < 400; c++) begin
            step();
            for (int i = 0; i < NR; i++)
                if (!req[i] && $urandom_range(3) == 0) issue(i, NB'($urandom), NB'($urandom));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cycle %0d: bench did not complete", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
